mem_arbiter: RTL

Shares one 4-phase req/ack memory port between the CPU instruction fetch port (i_*) and data port (d_*), so both can sit in a single SPRAM/BRAM image instead of separate i_mem/d_mem blocks. It sits between bfcpu and the unified memory in the top level. The data space is relocated by a base offset. A watchdog aborts transactions the memory never acknowledges.

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter:
// direction codes, grant identifiers, FSM states and the data-space relocation helper.
package mem_arbiter_pkg;

    localparam logic DIRECTION_READ  = 1'b0;
    localparam logic DIRECTION_WRITE = 1'b1;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_I_BUSY = 3'd1,
        ST_D_BUSY = 3'd2,
        ST_I_DONE = 3'd3,
        ST_D_DONE = 3'd4
    } state_t;

    // Data space sits at base + zero-extended 8-bit address, wrapping at 64K.
    function automatic logic [15:0] d_map(input logic [15:0] base, input logic [7:0] addr);
        return base + {8'h00, addr};
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin share of one 4-phase memory port between I-fetch and data ports; 1 cycle req->m_req and m_ack->ack.
// A port waits (ack low) while the other is served; a watchdog aborts unacknowledged accesses and sets sticky err.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter logic [15:0] D_BASE  = 16'h8000,
    parameter logic [15:0] TIMEOUT = 16'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_ack,
    output logic [7:0]  i_rdata,
    input  logic        d_req,
    input  logic        d_dir,
    input  logic [7:0]  d_addr,
    input  logic [7:0]  d_wdata,
    output logic        d_ack,
    output logic [7:0]  d_rdata,
    output logic        m_req,
    output logic        m_dir,
    output logic [15:0] m_addr,
    output logic [7:0]  m_wdata,
    input  logic        m_ack,
    input  logic [7:0]  m_rdata,
    output logic        err
);

    state_t      state, state_nxt;
    logic        last_grant, last_grant_nxt;
    logic [15:0] wdog, wdog_nxt;
    logic        m_req_nxt, m_dir_nxt, i_ack_nxt, d_ack_nxt, err_nxt;
    logic [15:0] m_addr_nxt;
    logic [7:0]  m_wdata_nxt, i_rdata_nxt, d_rdata_nxt;
    logic        pick_d;
    logic        finish;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= GRANT_D;
            wdog       <= '0;
            m_req      <= 1'b0;
            m_dir      <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            wdog       <= wdog_nxt;
            m_req      <= m_req_nxt;
            m_dir      <= m_dir_nxt;
            m_addr     <= m_addr_nxt;
            m_wdata    <= m_wdata_nxt;
            i_ack      <= i_ack_nxt;
            d_ack      <= d_ack_nxt;
            i_rdata    <= i_rdata_nxt;
            d_rdata    <= d_rdata_nxt;
            err        <= err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        wdog_nxt       = wdog;
        m_req_nxt      = m_req;
        m_dir_nxt      = m_dir;
        m_addr_nxt     = m_addr;
        m_wdata_nxt    = m_wdata;
        i_ack_nxt      = i_ack;
        d_ack_nxt      = d_ack;
        i_rdata_nxt    = i_rdata;
        d_rdata_nxt    = d_rdata;
        err_nxt        = err;
        // D wins only when alone or when I was served last.
        pick_d         = d_req && (!i_req || (last_grant == GRANT_I));
        finish         = m_ack || (wdog == TIMEOUT - 16'd1);

        case (state)
            ST_IDLE: begin
                if ((i_req || d_req) && !m_ack) begin
                    m_req_nxt = 1'b1;
                    wdog_nxt  = '0;
                    if (pick_d) begin
                        state_nxt   = ST_D_BUSY;
                        m_addr_nxt  = d_map(D_BASE, d_addr);
                        m_dir_nxt   = d_dir;
                        m_wdata_nxt = d_wdata;
                    end else begin
                        state_nxt  = ST_I_BUSY;
                        m_addr_nxt = i_addr;
                        m_dir_nxt  = DIRECTION_READ;
                    end
                end
            end
            ST_I_BUSY, ST_D_BUSY: begin
                if (finish) begin
                    // Aborted reads return 00 so a stale byte is never mistaken for data.
                    m_req_nxt = 1'b0;
                    if (!m_ack) err_nxt = 1'b1;
                    if (state == ST_D_BUSY) begin
                        d_ack_nxt      = 1'b1;
                        last_grant_nxt = GRANT_D;
                        state_nxt      = ST_D_DONE;
                        if (m_dir == DIRECTION_READ) d_rdata_nxt = m_ack ? m_rdata : 8'h00;
                    end else begin
                        i_ack_nxt      = 1'b1;
                        last_grant_nxt = GRANT_I;
                        state_nxt      = ST_I_DONE;
                        i_rdata_nxt    = m_ack ? m_rdata : 8'h00;
                    end
                end else begin
                    wdog_nxt = wdog + 16'd1;
                end
            end
            ST_I_DONE: begin
                if (!i_req && !m_ack) begin
                    i_ack_nxt = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end
            ST_D_DONE: begin
                if (!d_req && !m_ack) begin
                    d_ack_nxt = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
